// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants for the 800x600 @ 60 Hz VGA pipeline.
// The count width is also used for car and collision position widths.
package vga_timing_gen_pkg;

    localparam int unsigned CNT_W = 11;
    typedef logic [CNT_W-1:0] count_t;

    localparam int unsigned VGA_H_ACTIVE = 800;
    localparam int unsigned VGA_H_FP     = 40;
    localparam int unsigned VGA_H_SYNC   = 128;
    localparam int unsigned VGA_H_BP     = 88;
    localparam int unsigned VGA_V_ACTIVE = 600;
    localparam int unsigned VGA_V_FP     = 1;
    localparam int unsigned VGA_V_SYNC   = 4;
    localparam int unsigned VGA_V_BP     = 23;
    localparam bit          VGA_SYNC_POL = 1'b1;

    localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Half-open window test [lo, hi) used for the sync pulse decode.
    function automatic logic in_window(input count_t value, input count_t lo, input count_t hi);
        return (value >= lo) && (value < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle produced by vga_timing_gen and consumed by the VGA bus packer.
interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;

    count_t hcount;
    logic   hsync;
    logic   hblnk;
    count_t vcount;
    logic   vsync;
    logic   vblnk;
    logic   frame_start;
    logic   line_start;

    modport master (
        output hcount, hsync, hblnk, vcount, vsync, vblnk, frame_start, line_start
    );

    modport slave (
        input hcount, hsync, hblnk, vcount, vsync, vblnk, frame_start, line_start
    );

endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: a wrapping position counter plus combinational blank/sync decode
// of its current value. Used once per line (horizontal) and once per frame (vertical).
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned ACTIVE   = VGA_H_ACTIVE,
    parameter int unsigned FP       = VGA_H_FP,
    parameter int unsigned SYNC     = VGA_H_SYNC,
    parameter int unsigned BP       = VGA_H_BP,
    parameter bit          SYNC_POL = VGA_SYNC_POL
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   enable_i,
    output count_t count_o,
    output logic   blank_o,
    output logic   sync_o,
    output logic   wrap_o
);

    localparam count_t LAST_C       = count_t'(ACTIVE + FP + SYNC + BP - 1);
    localparam count_t BLANK_C      = count_t'(ACTIVE);
    localparam count_t SYNC_START_C = count_t'(ACTIVE + FP);
    localparam count_t SYNC_END_C   = count_t'(ACTIVE + FP + SYNC);

    count_t cnt_q;
    count_t cnt_d;

    // ">=" rather than "==" so an upset value beyond the last position still wraps.
    assign wrap_o = enable_i && (cnt_q >= LAST_C);

    always_comb begin
        cnt_d = cnt_q;
        if (wrap_o) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + count_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign blank_o = (cnt_q >= BLANK_C);
    assign sync_o  = in_window(cnt_q, SYNC_START_C, SYNC_END_C) ? SYNC_POL : ~SYNC_POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: chains a horizontal and a vertical axis counter and
// registers every decoded output so all of them describe the same pixel.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter bit          SYNC_POL = VGA_SYNC_POL
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga_o
);

    count_t h_cnt;
    count_t v_cnt;
    logic   h_blank;
    logic   h_sync;
    logic   h_wrap;
    logic   v_blank;
    logic   v_sync;
    logic   v_wrap_unused;

    vga_axis_counter #(
        .ACTIVE   (H_ACTIVE),
        .FP       (H_FP),
        .SYNC     (H_SYNC),
        .BP       (H_BP),
        .SYNC_POL (SYNC_POL)
    ) u_h_axis (
        .clk      (clk),
        .rst      (rst),
        .enable_i (1'b1),
        .count_o  (h_cnt),
        .blank_o  (h_blank),
        .sync_o   (h_sync),
        .wrap_o   (h_wrap)
    );

    // The vertical axis advances once per line; its own wrap has no consumer here.
    vga_axis_counter #(
        .ACTIVE   (V_ACTIVE),
        .FP       (V_FP),
        .SYNC     (V_SYNC),
        .BP       (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_v_axis (
        .clk      (clk),
        .rst      (rst),
        .enable_i (h_wrap),
        .count_o  (v_cnt),
        .blank_o  (v_blank),
        .sync_o   (v_sync),
        .wrap_o   (v_wrap_unused)
    );

    logic   line_start_d;
    logic   frame_start_d;
    count_t hcount_q;
    count_t vcount_q;
    logic   hsync_q;
    logic   hblnk_q;
    logic   vsync_q;
    logic   vblnk_q;
    logic   line_start_q;
    logic   frame_start_q;

    assign line_start_d  = (h_cnt == '0);
    assign frame_start_d = (h_cnt == '0) && (v_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~SYNC_POL;
            hblnk_q       <= 1'b0;
            vsync_q       <= ~SYNC_POL;
            vblnk_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= h_cnt;
            vcount_q      <= v_cnt;
            hsync_q       <= h_sync;
            hblnk_q       <= h_blank;
            vsync_q       <= v_sync;
            vblnk_q       <= v_blank;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_o.hcount      = hcount_q;
    assign vga_o.vcount      = vcount_q;
    assign vga_o.hsync       = hsync_q;
    assign vga_o.hblnk       = hblnk_q;
    assign vga_o.vsync       = vsync_q;
    assign vga_o.vblnk       = vblnk_q;
    assign vga_o.line_start  = line_start_q;
    assign vga_o.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 800x600 instance, an inverted-polarity twin and a
// tiny-raster instance whose short frame lets vertical and frame wraps be observed.
module tb_vga_timing_gen;
    import vga_timing_gen_pkg::*;

    localparam int SH_A = 8, SH_F = 2, SH_S = 3, SH_B = 2;
    localparam int SV_A = 5, SV_F = 1, SV_S = 2, SV_B = 2;
    localparam int SH_T = SH_A + SH_F + SH_S + SH_B;
    localparam int SV_T = SV_A + SV_F + SV_S + SV_B;

    typedef struct packed {
        logic [CNT_W-1:0] hc;
        logic [CNT_W-1:0] vc;
        logic             hs;
        logic             hb;
        logic             vs;
        logic             vb;
        logic             fs;
        logic             ls;
    } out_t;

    typedef struct {
        string name;
        int    p;
        int    sel;
        out_t  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if vgaA ();
    vga_timing_gen_if vgaN ();
    vga_timing_gen_if vgaS ();

    vga_timing_gen dutA (.clk(clk), .rst(rst), .vga_o(vgaA));

    vga_timing_gen #(.SYNC_POL(1'b0)) dutN (.clk(clk), .rst(rst), .vga_o(vgaN));

    vga_timing_gen #(
        .H_ACTIVE(SH_A), .H_FP(SH_F), .H_SYNC(SH_S), .H_BP(SH_B),
        .V_ACTIVE(SV_A), .V_FP(SV_F), .V_SYNC(SV_S), .V_BP(SV_B),
        .SYNC_POL(1'b1)
    ) dutS (.clk(clk), .rst(rst), .vga_o(vgaS));

    out_t actA, actN, actS;
    assign actA = {vgaA.hcount, vgaA.vcount, vgaA.hsync, vgaA.hblnk, vgaA.vsync, vgaA.vblnk, vgaA.frame_start, vgaA.line_start};
    assign actN = {vgaN.hcount, vgaN.vcount, vgaN.hsync, vgaN.hblnk, vgaN.vsync, vgaN.vblnk, vgaN.frame_start, vgaN.line_start};
    assign actS = {vgaS.hcount, vgaS.vcount, vgaS.hsync, vgaS.hblnk, vgaS.vsync, vgaS.vblnk, vgaS.frame_start, vgaS.line_start};

    int   tests = 0;
    int   fails = 0;
    int   pix = 0;
    int   errA, errN, errS;
    int   hsyncCntA, lineCntA, frameCntS, vsyncCntS, vblnkCntS;
    vec_t vecs[$];

    function automatic out_t mk(input int hc, input int vc, input bit hs, input bit hb,
                                input bit vs, input bit vb, input bit fs, input bit ls);
        out_t o;
        o.hc = CNT_W'(hc);
        o.vc = CNT_W'(vc);
        o.hs = hs;
        o.hb = hb;
        o.vs = vs;
        o.vb = vb;
        o.fs = fs;
        o.ls = ls;
        return o;
    endfunction

    function automatic out_t resetOut(input bit pol);
        return mk(0, 0, !pol, 1'b0, !pol, 1'b0, 1'b0, 1'b0);
    endfunction

    // Pixel p after release, for sel 0 = default, 1 = inverted default, 2 = tiny raster.
    function automatic out_t modelOut(input int p, input int sel);
        int ha, hf, hsw, ht, va, vf, vsw, vt, x, y;
        bit pol;
        if (sel == 2) begin
            ha = SH_A; hf = SH_F; hsw = SH_S; ht = SH_T;
            va = SV_A; vf = SV_F; vsw = SV_S; vt = SV_T;
        end else begin
            ha = VGA_H_ACTIVE; hf = VGA_H_FP; hsw = VGA_H_SYNC; ht = VGA_H_TOTAL;
            va = VGA_V_ACTIVE; vf = VGA_V_FP; vsw = VGA_V_SYNC; vt = VGA_V_TOTAL;
        end
        pol = (sel != 1);
        x = p % ht;
        y = (p / ht) % vt;
        return mk(x, y,
                  (x >= ha + hf && x < ha + hf + hsw) ? pol : !pol,
                  x >= ha,
                  (y >= va + vf && y < va + vf + vsw) ? pol : !pol,
                  y >= va,
                  (x == 0 && y == 0), (x == 0));
    endfunction

    task automatic checkOutput(input string name, input out_t act, input out_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got hc=%0d vc=%0d hs=%b hb=%b vs=%b vb=%b fs=%b ls=%b, want hc=%0d vc=%0d hs=%b hb=%b vs=%b vb=%b fs=%b ls=%b",
                     name, act.hc, act.vc, act.hs, act.hb, act.vs, act.vb, act.fs, act.ls,
                     exp.hc, exp.vc, exp.hs, exp.hb, exp.vs, exp.vb, exp.fs, exp.ls);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic startPhase();
        pix = 0;
        errA = 0; errN = 0; errS = 0;
        hsyncCntA = 0; lineCntA = 0; frameCntS = 0; vsyncCntS = 0; vblnkCntS = 0;
    endtask

    // Advance n clocks, comparing every DUT to the model and firing matching table vectors.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (actA !== modelOut(pix, 0)) begin
                if (errA == 0) $display("[TB] default raster diverges at pixel index %0d", pix);
                errA++;
            end
            if (actN !== modelOut(pix, 1)) begin
                if (errN == 0) $display("[TB] inverted raster diverges at pixel index %0d", pix);
                errN++;
            end
            if (actS !== modelOut(pix, 2)) begin
                if (errS == 0) $display("[TB] tiny raster diverges at pixel index %0d", pix);
                errS++;
            end
            if (pix < VGA_H_TOTAL && actA.hs) hsyncCntA++;
            if (actA.ls) lineCntA++;
            if (actS.fs) frameCntS++;
            if (pix < SH_T * SV_T && actS.vs) vsyncCntS++;
            if (pix < SH_T * SV_T && actS.vb) vblnkCntS++;
            foreach (vecs[i]) begin
                if (vecs[i].p == pix)
                    checkOutput(vecs[i].name, (vecs[i].sel == 2) ? actS : actA, vecs[i].exp);
            end
            pix++;
        end
    endtask

    task automatic checkPhase(input string tag, input int n);
        checkCount({tag, " default model errors"}, errA, 0);
        checkCount({tag, " inverted-polarity model errors"}, errN, 0);
        checkCount({tag, " tiny model errors"}, errS, 0);
        checkCount({tag, " line_start pulses"}, lineCntA, (n + VGA_H_TOTAL - 1) / VGA_H_TOTAL);
        checkCount({tag, " tiny frame_start pulses"}, frameCntS, (n + SH_T * SV_T - 1) / (SH_T * SV_T));
        checkCount({tag, " tiny vsync cycles per frame"}, vsyncCntS, SV_S * SH_T);
        checkCount({tag, " tiny vblnk cycles per frame"}, vblnkCntS, (SV_T - SV_A) * SH_T);
    endtask

    initial begin
        vecs.push_back('{"A first pixel",      0,    0, mk(0,    0, 0, 0, 0, 0, 1, 1)});
        vecs.push_back('{"A second pixel",     1,    0, mk(1,    0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"A last active",      799,  0, mk(799,  0, 0, 0, 0, 0, 0, 0)});
        vecs.push_back('{"A blank start",      800,  0, mk(800,  0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{"A before hsync",     839,  0, mk(839,  0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{"A hsync start",      840,  0, mk(840,  0, 1, 1, 0, 0, 0, 0)});
        vecs.push_back('{"A hsync last",       967,  0, mk(967,  0, 1, 1, 0, 0, 0, 0)});
        vecs.push_back('{"A hsync end",        968,  0, mk(968,  0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{"A line end",         1055, 0, mk(1055, 0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{"A line wrap",        1056, 0, mk(0,    1, 0, 0, 0, 0, 0, 1)});
        vecs.push_back('{"A line 1 end",       2111, 0, mk(1055, 1, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{"A line 2 start",     2112, 0, mk(0,    2, 0, 0, 0, 0, 0, 1)});
        vecs.push_back('{"S blank start",      8,    2, mk(8,    0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{"S hsync start",      10,   2, mk(10,   0, 1, 1, 0, 0, 0, 0)});
        vecs.push_back('{"S hsync end",        13,   2, mk(13,   0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{"S line end",         14,   2, mk(14,   0, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{"S line wrap",        15,   2, mk(0,    1, 0, 0, 0, 0, 0, 1)});
        vecs.push_back('{"S last active line", 74,   2, mk(14,   4, 0, 1, 0, 0, 0, 0)});
        vecs.push_back('{"S vblank start",     75,   2, mk(0,    5, 0, 0, 0, 1, 0, 1)});
        vecs.push_back('{"S vsync start",      90,   2, mk(0,    6, 0, 0, 1, 1, 0, 1)});
        vecs.push_back('{"S vsync last",       119,  2, mk(14,   7, 0, 1, 1, 1, 0, 0)});
        vecs.push_back('{"S vsync end",        120,  2, mk(0,    8, 0, 0, 0, 1, 0, 1)});
        vecs.push_back('{"S frame end",        149,  2, mk(14,   9, 0, 1, 0, 1, 0, 0)});
        vecs.push_back('{"S frame wrap",       150,  2, mk(0,    0, 0, 0, 0, 0, 1, 1)});

        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("reset default", actA, resetOut(1'b1));
        checkOutput("reset inverted", actN, resetOut(1'b0));
        checkOutput("reset tiny", actS, resetOut(1'b1));

        @(negedge clk);
        rst = 1'b1;
        startPhase();
        applyStimulus(2300);
        checkCount("first line hsync cycles", hsyncCntA, VGA_H_SYNC);
        checkPhase("run1", 2300);

        // Stop with the tiny raster presenting (4,3), then reset between clock edges.
        for (int i = 0; i < SH_T * SV_T && (pix % (SH_T * SV_T)) != 3 * SH_T + 5; i++)
            applyStimulus(1);
        checkOutput("tiny before mid-frame reset", actS, mk(4, 3, 0, 0, 0, 0, 0, 0));
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async reset default", actA, resetOut(1'b1));
        checkOutput("async reset inverted", actN, resetOut(1'b0));
        checkOutput("async reset tiny", actS, resetOut(1'b1));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("held reset tiny", actS, resetOut(1'b1));

        @(negedge clk);
        rst = 1'b1;
        startPhase();
        applyStimulus(300);
        checkPhase("run2", 300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
